// File: rtl/pad_mask_pkg.sv
// Shared types and constants for the pad-mask load controller.
package pad_mask_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 8;
  localparam int BANK_W       = 2;

  // Default handshake timeouts, in clock cycles.
  localparam int START_TO_DEF = 8;
  localparam int BUSY_TO_DEF  = 256;

  // Controller states, kept as plain constants so older tools can consume them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WRITE   = 3'd1;
  localparam state_t ST_START   = 3'd2;
  localparam state_t ST_WAIT_HI = 3'd3;
  localparam state_t ST_WAIT_LO = 3'd4;

endpackage

// File: rtl/pad_mask_bank_timer.sv
// Loadable down-counter for the serializer handshake waits.
// Loaded on entry to a wait state; expired is high once it reaches zero.
module pad_mask_bank_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  import pad_mask_pkg::*;

  logic [CNT_W-1:0] cnt;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pad_mask_load_ctrl.sv
// Pad-mask RAM controller: arbitrates config writes against serializer
// reloads, sequences one bank's start/busy handshake at a time, and tracks
// dirty / mask_valid state per bank.
module pad_mask_load_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int START_TO  = 8,
  parameter int BUSY_TO   = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_wr_req,
  input  logic [1:0]           cfg_wr_bank,
  input  logic [ADDR_W-1:0]    cfg_wr_addr,
  input  logic [DATA_W-1:0]    cfg_wr_data,
  output logic                 cfg_wr_ack,
  input  logic                 reload_req,
  output logic [NUM_BANKS-1:0] ram_sel,
  output logic [NUM_BANKS-1:0] ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_din,
  output logic [NUM_BANKS-1:0] bank_start,
  input  logic [NUM_BANKS-1:0] bank_busy,
  output logic [NUM_BANKS-1:0] mask_valid,
  output logic                 ctrl_busy,
  output logic                 reload_done,
  output logic                 err_timeout,
  output logic [1:0]           err_bank
);
  import pad_mask_pkg::*;

  localparam int TMAX  = (START_TO > BUSY_TO) ? START_TO : BUSY_TO;
  localparam int CNT_W = $clog2(TMAX + 1);

  state_t              state, state_nxt;
  logic [BANK_W-1:0]   cur_bank, low_idx;
  logic [NUM_BANKS-1:0] dirty, dirty_nxt, mv_nxt, bank_oh;
  logic                stale;
  logic                tmr_load, tmr_exp;
  logic [CNT_W-1:0]    tmr_val;
  logic                done, tout, in_flight, done_ok;

  pad_mask_bank_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Lowest-indexed dirty bank wins the next reload slot.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--)
      if (dirty[i]) low_idx = BANK_W'(i);
  end

  // One-hot decode of the bank currently owned by the FSM.
  always_comb begin
    bank_oh = '0;
    bank_oh[cur_bank] = 1'b1;
  end

  // Next-state logic; the timer is reloaded on entry to each wait state.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    done      = 1'b0;
    tout      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_wr_req)   state_nxt = ST_WRITE;
        else if (|dirty)  state_nxt = ST_START;
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_START: begin
        state_nxt = ST_WAIT_HI;
        tmr_load  = 1'b1;
        tmr_val   = CNT_W'(START_TO - 1);
      end
      ST_WAIT_HI: begin
        if (bank_busy[cur_bank]) begin
          state_nxt = ST_WAIT_LO;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(BUSY_TO - 1);
        end else if (tmr_exp) begin
          state_nxt = ST_IDLE;
          tout      = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!bank_busy[cur_bank]) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end else if (tmr_exp) begin
          state_nxt = ST_IDLE;
          tout      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_flight = (state == ST_START) || (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
  // A completion only counts if no reload request raced it.
  assign done_ok   = done && !stale && !reload_req;

  // Dirty / mask_valid update; a reload request overrides everything else.
  always_comb begin
    dirty_nxt = dirty;
    mv_nxt    = mask_valid;
    if (state == ST_WRITE) begin
      dirty_nxt[cur_bank] = 1'b1;
      mv_nxt[cur_bank]    = 1'b0;
    end
    if ((done || tout) && !stale) dirty_nxt[cur_bank] = 1'b0;
    if (done_ok) mv_nxt[cur_bank] = 1'b1;
    if (reload_req) begin
      dirty_nxt = '1;
      mv_nxt    = '0;
    end
  end

  // Control state, captured write payload, and bank bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cur_bank    <= '0;
      ram_addr    <= '0;
      ram_din     <= '0;
      dirty       <= '1;
      mask_valid  <= '0;
      stale       <= 1'b0;
      reload_done <= 1'b0;
      err_timeout <= 1'b0;
      err_bank    <= '0;
      ctrl_busy   <= 1'b0;
    end else begin
      state       <= state_nxt;
      dirty       <= dirty_nxt;
      mask_valid  <= mv_nxt;
      reload_done <= done_ok;
      // Registered copy of the next-cycle busy condition so it reads 0 in reset.
      ctrl_busy   <= (state_nxt != ST_IDLE) || (|dirty_nxt);
      if (state == ST_IDLE) begin
        if (cfg_wr_req) begin
          cur_bank <= cfg_wr_bank;
          ram_addr <= cfg_wr_addr;
          ram_din  <= cfg_wr_data;
        end else if (|dirty) begin
          cur_bank <= low_idx;
        end
      end
      if (done || tout)                stale <= 1'b0;
      else if (reload_req && in_flight) stale <= 1'b1;
      if (tout) begin
        err_timeout <= 1'b1;
        err_bank    <= cur_bank;
      end
    end
  end

  assign cfg_wr_ack = (state == ST_WRITE);
  assign ram_sel    = (state == ST_WRITE) ? bank_oh : '0;
  assign ram_we     = (state == ST_WRITE) ? bank_oh : '0;
  assign bank_start = (state == ST_START) ? bank_oh : '0;

endmodule

// File: tb/tb_pad_mask_load_ctrl.sv
// Scoreboard bench for pad_mask_load_ctrl with a simple serializer model.
module tb_pad_mask_load_ctrl;

  localparam int START_TO = 8;
  localparam int BUSY_LEN = 10;

  logic       clk, reset;
  logic       cfg_wr_req;
  logic [1:0] cfg_wr_bank;
  logic [8:0] cfg_wr_addr;
  logic [7:0] cfg_wr_data;
  logic       cfg_wr_ack, reload_req;
  logic [3:0] ram_sel, ram_we, bank_start, bank_busy, mask_valid;
  logic [8:0] ram_addr;
  logic [7:0] ram_din;
  logic       ctrl_busy, reload_done, err_timeout;
  logic [1:0] err_bank;

  pad_mask_load_ctrl #(.NUM_BANKS(4), .ADDR_W(9), .DATA_W(8),
                       .START_TO(START_TO), .BUSY_TO(256)) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_req(cfg_wr_req), .cfg_wr_bank(cfg_wr_bank),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_ack(cfg_wr_ack), .reload_req(reload_req),
    .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .bank_start(bank_start), .bank_busy(bank_busy), .mask_valid(mask_valid),
    .ctrl_busy(ctrl_busy), .reload_done(reload_done),
    .err_timeout(err_timeout), .err_bank(err_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: busy for BUSY_LEN cycles starting the cycle after start.
  logic [3:0] no_rise;
  int         busy_left [4];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_busy <= '0;
      for (int b = 0; b < 4; b++) busy_left[b] <= 0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bank_start[b] && !no_rise[b]) begin
          bank_busy[b] <= 1'b1;
          busy_left[b] <= BUSY_LEN - 1;
        end else if (bank_busy[b]) begin
          if (busy_left[b] == 0) bank_busy[b] <= 1'b0;
          else                   busy_left[b] <= busy_left[b] - 1;
        end
      end
    end
  end

  typedef struct { int kind; logic [31:0] val; } ev_t;
  localparam int EV_WR = 0, EV_START = 1, EV_DONE = 2, EV_ERR = 3;
  ev_t exp_q[$];
  int  n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] wr_ev(input logic [3:0] oh, input logic [8:0] a, input logic [7:0] d);
    return {7'b0, oh, oh, a, d};
  endfunction

  task automatic got(input int kind, input logic [31:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d val %h expected none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_val", val, e.val);
    end
  endtask

  // Monitor: every visible DUT event is matched against the queue.
  initial begin
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) err_prev = 1'b0;
      else begin
        if (cfg_wr_ack)  got(EV_WR, {7'b0, ram_we, ram_sel, ram_addr, ram_din});
        if (|bank_start) got(EV_START, {28'b0, bank_start});
        if (reload_done) got(EV_DONE, {28'b0, mask_valid});
        if (err_timeout && !err_prev) got(EV_ERR, {30'b0, err_bank});
        err_prev = err_timeout;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !ctrl_busy) begin ok = 1; break; end
    end
    check("idle_reached", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_start(input int b);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bank_start[b]) begin ok = 1; break; end
    end
    check("start_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic do_write(input logic [1:0] b, input logic [8:0] a, input logic [7:0] d, output int lat);
    bit ok = 0;
    lat = -1;
    @(posedge clk); #1;
    cfg_wr_req = 1'b1; cfg_wr_bank = b; cfg_wr_addr = a; cfg_wr_data = d;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cfg_wr_ack) begin ok = 1; lat = i; break; end
    end
    cfg_wr_req = 1'b0;
    check("ack_seen", {31'b0, ok}, 32'd1);
  endtask

  task automatic pulse_reload();
    @(posedge clk); #1 reload_req = 1'b1;
    @(posedge clk); #1 reload_req = 1'b0;
  endtask

  task automatic push_full_reload(input logic [3:0] final_skip);
    logic [3:0] mv;
    mv = '0;
    for (int b = 0; b < 4; b++) begin
      push(EV_START, 32'(4'b1 << b));
      if (!final_skip[b]) begin
        mv[b] = 1'b1;
        push(EV_DONE, {28'b0, mv});
      end else push(EV_ERR, 32'(b));
    end
  endtask

  initial begin
    int lat, n;
    reset = 1'b0; cfg_wr_req = 1'b0; cfg_wr_bank = '0; cfg_wr_addr = '0;
    cfg_wr_data = '0; reload_req = 1'b0; no_rise = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mask_valid", {28'b0, mask_valid}, 32'h0);
    check("rst_outputs", {ctrl_busy, cfg_wr_ack, reload_done, err_timeout, err_bank, ram_we, ram_sel, bank_start},
          32'h0);
    check("rst_addr_data", {ram_addr, ram_din}, 32'h0);

    // Post-reset automatic reload of all four banks, in order.
    push_full_reload(4'b0000);
    @(negedge clk) reset = 1'b1;
    wait_idle();
    check("init_mask_valid", {28'b0, mask_valid}, 32'hF);
    check("init_no_error", {31'b0, err_timeout}, 32'h0);

    // Idle write to bank 2, then its reload.
    push(EV_WR, wr_ev(4'b0100, 9'h005, 8'hA5));
    push(EV_START, 32'h4);
    push(EV_DONE, 32'hF);
    do_write(2'd2, 9'h005, 8'hA5, lat);
    check("wr_ack_latency", lat, 32'd1);
    @(negedge clk);
    check("wr_mask_drop", {28'b0, mask_valid}, 32'hB);
    wait_idle();

    // Write held during bank 1 WAIT_LO is deferred until IDLE.
    push(EV_WR, wr_ev(4'b0010, 9'h01A, 8'h3C));
    push(EV_START, 32'h2);
    push(EV_DONE, 32'hF);
    push(EV_WR, wr_ev(4'b0001, 9'h1FF, 8'h5A));
    push(EV_START, 32'h1);
    push(EV_DONE, 32'hF);
    do_write(2'd1, 9'h01A, 8'h3C, lat);
    wait_start(1);
    repeat (2) @(negedge clk);
    do_write(2'd0, 9'h1FF, 8'h5A, lat);
    check("held_wr_latency", lat, 32'd10);
    wait_idle();
    check("held_wr_mask", {28'b0, mask_valid}, 32'hF);

    // Reload request during bank 3 WAIT_LO: that completion is discarded.
    push(EV_WR, wr_ev(4'b1000, 9'h100, 8'hC3));
    push(EV_START, 32'h8);
    push_full_reload(4'b0000);
    do_write(2'd3, 9'h100, 8'hC3, lat);
    wait_start(3);
    repeat (3) @(negedge clk);
    pulse_reload();
    wait_start(0);
    check("stale_mask_cleared", {28'b0, mask_valid}, 32'h0);
    wait_idle();
    check("stale_final_mask", {28'b0, mask_valid}, 32'hF);

    // Bank 0 never raises busy: start timeout, others still reload.
    no_rise = 4'b0001;
    push_full_reload(4'b0001);
    pulse_reload();
    wait_start(0);
    n = -1;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (err_timeout) begin n = i; break; end
    end
    check("timeout_latency", n, START_TO + 1);
    wait_idle();
    check("timeout_mask", {28'b0, mask_valid}, 32'hE);
    check("timeout_err", {29'b0, err_timeout, err_bank}, 32'h4);

    // Reset asserted in WAIT_HI, then a full reload after release.
    push(EV_START, 32'h1);
    pulse_reload();
    wait_start(0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_outputs", {mask_valid, ctrl_busy, cfg_wr_ack, reload_done, err_timeout, err_bank,
                             ram_we, ram_sel, bank_start}, 32'h0);
    check("midrst_queue_empty", exp_q.size(), 32'd0);
    no_rise = '0;
    repeat (2) @(posedge clk);
    push_full_reload(4'b0000);
    @(negedge clk) reset = 1'b1;
    wait_idle();
    check("rerst_mask", {28'b0, mask_valid}, 32'hF);
    check("rerst_err_clear", {31'b0, err_timeout}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pad_mask_load_ctrl.md
# pad_mask_load_ctrl

Controller for the four pad-mask RAM banks and their serial-readout engines in the strip trigger path. It arbitrates between configuration writes (from VIO or slow control) and mask reloads into the serializers, and sequences per-bank `start`/`busy` handshakes one bank at a time. It also tracks which banks are stale (dirty) and drives a per-bank `mask_valid` flag so downstream logic-pad matching can ignore a bank whose mask is being rewritten.

## Interface
Parameters:
- `NUM_BANKS`, 4, number of mask RAM / serializer pairs
- `ADDR_W`, 9, RAM address width
- `DATA_W`, 8, RAM data width
- `START_TO`, 8, maximum cycles from `bank_start` to `bank_busy` high
- `BUSY_TO`, 256, maximum cycles `bank_busy` may stay high

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cfg_wr_req`  in  1  write request, level; held until ack
- `cfg_wr_bank`  in  2  target bank, valid with req
- `cfg_wr_addr`  in  ADDR_W  target address
- `cfg_wr_data`  in  DATA_W  write data
- `cfg_wr_ack`  out  1  one-cycle pulse: write performed
- `reload_req`  in  1  pulse: mark all banks dirty
- `ram_sel`  out  NUM_BANKS  1 = config path owns bank address mux
- `ram_we`  out  NUM_BANKS  one-hot write enable
- `ram_addr`  out  ADDR_W  registered config address, shared
- `ram_din`  out  DATA_W  registered config data, shared
- `bank_start`  out  NUM_BANKS  one-cycle serializer start
- `bank_busy`  in  NUM_BANKS  serializer busy
- `mask_valid`  out  NUM_BANKS  bank mask loaded and current
- `ctrl_busy`  out  1  FSM not IDLE or any bank dirty
- `reload_done`  out  1  one-cycle pulse on successful bank reload
- `err_timeout`  out  1  sticky handshake-timeout flag
- `err_bank`  out  2  bank of most recent timeout

## Operation
- States: IDLE, WRITE, START, WAIT_HI, WAIT_LO.
- IDLE priority: `cfg_wr_req` first, then the lowest-indexed dirty bank, otherwise stay.
- WRITE (1 cycle): `ram_sel[b]`=1, `ram_we[b]`=1, `ram_addr`/`ram_din` hold the captured values, `cfg_wr_ack`=1. Set `dirty[b]` and clear `mask_valid[b]`. Return to IDLE.
- START (1 cycle): `bank_start[b]`=1 and `ram_sel[b]`=0. Go to WAIT_HI.
- WAIT_HI: when `bank_busy[b]`=1, go to WAIT_LO. After START_TO cycles without it, take the timeout exit.
- WAIT_LO: when `bank_busy[b]`=0, clear `dirty[b]`, set `mask_valid[b]`, pulse `reload_done`, and go to IDLE. After BUSY_TO cycles still busy, take the timeout exit.
- Timeout exit: set `err_timeout` and `err_bank`=b, clear `dirty[b]` (no livelock), keep `mask_valid[b]`=0, go to IDLE.
- `reload_req`: sets every `dirty` bit and clears every `mask_valid` bit on the next cycle, in any state.
- A `reload_req` arriving while bank b is in WAIT_* re-dirties b. The in-flight completion must not clear that new dirty bit or set `mask_valid[b]`, so b reloads again.
- Writes are not accepted outside IDLE. `cfg_wr_req` stays pending, unacked.
- `ram_sel` defaults to 0 in every state except WRITE.
- Reset values: all outputs 0, `dirty`=all ones, `mask_valid`=0, state IDLE. All banks therefore reload automatically after reset.
- `err_timeout` clears only on reset.

## Timing
- Write: req seen in IDLE at cycle N, then `ram_we`/`ack` at N+1, then IDLE at N+2. A held req produces a write every 2 cycles, so the requester drops req on ack.
- Reload: dirty bank selected at IDLE cycle M, then `bank_start` at M+1. `mask_valid` rises on the cycle after busy is seen low.
- Writes have priority over pending reloads only at IDLE decisions. An in-progress reload is never preempted.
- Reset may assert in any state. All outputs drop to reset values asynchronously. Serializers are reset by the same signal.

## Structure
- Package `pad_mask_pkg` holds:
  - the state enum,
  - `NUM_BANKS`, `ADDR_W`, `DATA_W`,
  - default timeout constants.
- Sub-module `pad_mask_bank_timer` is a loadable down-counter shared by WAIT_HI and WAIT_LO. It reloads on state entry and flags expiry.
- The address/data muxing between `ram_sel` and serializer addresses lives outside this block.

## Test plan
- Reset release, each serializer busy for 10 cycles → banks start in order 0,1,2,3; 4 `reload_done` pulses; `mask_valid`=4'b1111; `ctrl_busy`=0.
- Write bank 2, addr 9'h05, data 8'hA5 while idle → `ram_we`=4'b0100, `ram_addr`=9'h05, `ram_din`=8'hA5, ack at N+1. `mask_valid[2]` drops, then bank 2 reloads.
- `cfg_wr_req` held during bank 1 WAIT_LO → no ack until IDLE. Write acked next, then bank 1 is not re-dirtied unless targeted.
- `reload_req` during bank 3 WAIT_LO → after completion `mask_valid[3]` stays 0. Bank 3 restarts after banks 0–2.
- Bank 0 busy never rises → `err_timeout`=1, `err_bank`=0 after START_TO cycles. `mask_valid[0]`=0; banks 1–3 proceed.
- Reset asserted in WAIT_HI → outputs zero immediately; after release, full 4-bank reload repeats.
